// File: rtl/dma_cmd_sequencer.sv
// Timed command sequencer: queues command entries and replays them as per-channel
// command-register strobes, direction levels and start addresses for NUM_CH DMA channels.
module dma_cmd_sequencer #(
    parameter int ADDR_W  = 64,
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 8,
    parameter int DELAY_W = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       flush,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [2:0]                 cmd_ch,
    input  logic [DELAY_W-1:0]         cmd_delay,
    input  logic                       cmd_wait_idle,
    input  logic                       cmd_dir,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [NUM_CH-1:0]          dma_busy,
    output logic [NUM_CH-1:0]          command_reg_write,
    output logic [NUM_CH-1:0]          command_reg_continue,
    output logic [NUM_CH-1:0]          STOP,
    output logic [NUM_CH-1:0]          direction,
    output logic [NUM_CH*ADDR_W-1:0]   starting_address,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       seq_idle,
    output logic                       err_badch,
    output logic [1:0]                 dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_CONT  = 2'd1;
    localparam logic [1:0] OP_DIR   = 2'd2;
    localparam logic [1:0] OP_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_WAIT  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]         op;
        logic [2:0]         ch;
        logic [DELAY_W-1:0] delay;
        logic               wait_idle;
        logic               dir;
        logic [ADDR_W-1:0]  addr;
    } entry_t;

    state_t             state, state_nx;
    entry_t             mem [DEPTH];
    entry_t             head, hold;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   count;
    logic [DELAY_W-1:0] cnt;
    logic               push, pop, issue, head_bad, need_wait, busy_sel;
    logic [31:0]        head_ch32;
    logic [NUM_CH-1:0]  ch_onehot;

    // Handshake: an entry transfers on a rising edge where cmd_valid && cmd_ready
    // (and no flush); cmd_ready depends only on the current fill level.
    assign cmd_ready  = (count != LVL_W'(DEPTH));
    assign push       = cmd_valid && cmd_ready && !flush;
    assign fifo_level = count;
    assign seq_idle   = (state == S_IDLE) && (count == '0);
    assign dbg_state  = state;

    assign head      = mem[rd_ptr];
    assign head_ch32 = 32'(head.ch);
    assign head_bad  = (head_ch32 >= 32'(NUM_CH));
    assign need_wait = hold.wait_idle && ((hold.op == OP_START) || (hold.op == OP_CONT));
    assign busy_sel  = |(dma_busy & ch_onehot);

    always_comb begin
        ch_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_onehot[k] = (hold.ch == 3'(k));
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, ch: cmd_ch, delay: cmd_delay,
                             wait_idle: cmd_wait_idle, dir: cmd_dir, addr: cmd_addr};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + LVL_W'(1);
            else if (pop && !push) count <= count - LVL_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        issue    = 1'b0;
        case (state)
            S_IDLE: begin
                // Bad-channel entries are discarded at pop and never leave IDLE.
                if (count != '0) begin
                    pop = 1'b1;
                    if (!head_bad) state_nx = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    if (need_wait) begin
                        state_nx = S_WAIT;
                    end else begin
                        state_nx = S_ISSUE;
                        issue    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!busy_sel) begin
                    state_nx = S_ISSUE;
                    issue    = 1'b1;
                end
            end
            S_ISSUE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) begin
            state_nx = S_IDLE;
            pop      = 1'b0;
            issue    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hold      <= '0;
            cnt       <= '0;
            err_badch <= 1'b0;
        end else if (flush) begin
            hold <= '0;
            cnt  <= '0;
        end else begin
            if (pop && head_bad) err_badch <= 1'b1;
            if (pop && !head_bad) begin
                hold <= head;
                cnt  <= head.delay;
            end else if (state == S_DELAY && cnt != '0) begin
                cnt <= cnt - DELAY_W'(1);
            end
        end
    end

    // Strobes rise on the same edge the FSM enters ISSUE, so they are high for the ISSUE cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            command_reg_write    <= '0;
            command_reg_continue <= '0;
            STOP                 <= '0;
            direction            <= '1;
            starting_address     <= '0;
        end else begin
            command_reg_write    <= '0;
            command_reg_continue <= '0;
            STOP                 <= '0;
            if (issue) begin
                case (hold.op)
                    OP_START: begin
                        command_reg_write <= ch_onehot;
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_onehot[k]) starting_address[k*ADDR_W +: ADDR_W] <= hold.addr;
                        end
                    end
                    OP_CONT: command_reg_continue <= ch_onehot;
                    OP_DIR: begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_onehot[k]) direction[k] <= hold.dir;
                        end
                    end
                    OP_STOP: STOP <= ch_onehot;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed bench for dma_cmd_sequencer: a timestamp-based schedule model checked every
// cycle, plus hand-computed latency and boundary expectations.
module tb_dma_cmd_sequencer;

  localparam int ADDR_W  = 64;
  localparam int NUM_CH  = 2;
  localparam int DEPTH   = 8;
  localparam int DELAY_W = 16;
  localparam int ENT_W   = 2 + 3 + DELAY_W + 1 + 1 + ADDR_W;

  logic                   CLK = 1'b0;
  logic                   RESET = 1'b0;
  logic                   flush = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [1:0]             cmd_op = '0;
  logic [2:0]             cmd_ch = '0;
  logic [DELAY_W-1:0]     cmd_delay = '0;
  logic                   cmd_wait_idle = 1'b0;
  logic                   cmd_dir = 1'b0;
  logic [ADDR_W-1:0]      cmd_addr = '0;
  logic [NUM_CH-1:0]      dma_busy = '0;
  logic [NUM_CH-1:0]      command_reg_write;
  logic [NUM_CH-1:0]      command_reg_continue;
  logic [NUM_CH-1:0]      STOP;
  logic [NUM_CH-1:0]      direction;
  logic [NUM_CH*ADDR_W-1:0] starting_address;
  logic [3:0]             fifo_level;
  logic                   seq_idle;
  logic                   err_badch;
  logic [1:0]             dbg_state;

  dma_cmd_sequencer #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DELAY_W(DELAY_W)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_delay(cmd_delay), .cmd_wait_idle(cmd_wait_idle),
    .cmd_dir(cmd_dir), .cmd_addr(cmd_addr), .dma_busy(dma_busy),
    .command_reg_write(command_reg_write), .command_reg_continue(command_reg_continue),
    .STOP(STOP), .direction(direction), .starting_address(starting_address),
    .fifo_level(fifo_level), .seq_idle(seq_idle), .err_badch(err_badch), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard model: queued entries plus an issue timestamp for the entry in flight
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] m_e;
  longint           cyc = 0;
  longint           m_at = 0;
  longint           m_free = 0;
  bit               m_fly = 0;
  bit               m_wmode = 0;
  bit               issued, go;
  int               sz, m_ch;
  logic [1:0]       m_op;
  logic             m_dir;
  logic [63:0]      m_addr;
  logic [1:0]       exp_wr = '0, exp_cont = '0, exp_stop = '0, exp_dir = '1;
  logic [127:0]     exp_addr = '0;
  logic             exp_err = 0, exp_idle = 1;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exp_q.delete();
      m_fly = 0; m_free = 0;
      exp_wr = '0; exp_cont = '0; exp_stop = '0; exp_dir = '1; exp_addr = '0;
      exp_err = 0; exp_idle = 1;
    end else begin
      cyc++;
      exp_wr = '0; exp_cont = '0; exp_stop = '0;
      issued = 0;
      if (flush) begin
        exp_q.delete();
        m_fly = 0;
        m_free = cyc + 1;
        exp_idle = 1;
      end else begin
        sz = exp_q.size();
        if (m_fly) begin
          if (m_wmode) go = (cyc >= m_at) && !dma_busy[m_ch];
          else         go = (cyc == m_at);
          if (go) begin
            case (m_op)
              2'd0: begin exp_wr[m_ch] = 1'b1; exp_addr[m_ch*64 +: 64] = m_addr; end
              2'd1: exp_cont[m_ch] = 1'b1;
              2'd2: exp_dir[m_ch] = m_dir;
              default: exp_stop[m_ch] = 1'b1;
            endcase
            issued = 1; m_fly = 0; m_free = cyc + 2;
          end
        end
        if (!m_fly && cyc >= m_free && sz > 0) begin
          m_e = exp_q.pop_front();
          if (int'(m_e[84:82]) >= NUM_CH) begin
            exp_err = 1;
            m_free = cyc + 1;
          end else begin
            m_op = m_e[86:85]; m_ch = int'(m_e[84:82]); m_dir = m_e[64]; m_addr = m_e[63:0];
            m_fly = 1;
            m_wmode = m_e[65] && (m_e[86:85] <= 2'd1);
            m_at = cyc + longint'(m_e[81:66]) + (m_wmode ? 2 : 1);
          end
        end
        if (cmd_valid && sz < DEPTH)
          exp_q.push_back({cmd_op, cmd_ch, cmd_delay, cmd_wait_idle, cmd_dir, cmd_addr});
        exp_idle = !m_fly && !issued && (exp_q.size() == 0);
      end
    end
  end

  always @(negedge CLK) begin
    chk("write", command_reg_write, exp_wr);
    chk("continue", command_reg_continue, exp_cont);
    chk("stop", STOP, exp_stop);
    chk("direction", direction, exp_dir);
    chk("address", starting_address, exp_addr);
    chk("level", fifo_level, exp_q.size());
    chk("ready", cmd_ready, exp_q.size() < DEPTH);
    chk("seq_idle", seq_idle, exp_idle);
    chk("err_badch", err_badch, exp_err);
  end

  // driver tasks (called at posedge+1; return at posedge+1 after the accepting edge)
  longint last_push = 0;

  task automatic push_cmd(input logic [1:0] op, input int ch, input int dly, input bit wt,
                          input bit dir, input logic [63:0] addr);
    bit done = 0;
    cmd_valid = 1; cmd_op = op; cmd_ch = 3'(ch); cmd_delay = DELAY_W'(dly);
    cmd_wait_idle = wt; cmd_dir = dir; cmd_addr = addr;
    for (int i = 0; i < 300 && !done; i++) begin
      done = cmd_ready;
      @(posedge CLK); #1;
    end
    cmd_valid = 0;
    last_push = cyc;
    chk("push_accepted", done, 1'b1);
  endtask

  task automatic align;
    @(posedge CLK); #1;
  endtask

  longint p0, pa, t_ev, b_cyc;
  longint s_cyc[$];
  bit     seen;
  int     n_seen;

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET = 1;
    @(negedge CLK);
    chk("rst_seq_idle", seq_idle, 1'b1);
    chk("rst_direction", direction, 2'b11);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", cmd_ready, 1'b1);
    align();

    // START ch0 0x1000, delay 0: pop one edge after push, strobe the edge after that
    push_cmd(2'd0, 0, 0, 0, 0, 64'h1000);
    p0 = last_push;
    @(negedge CLK); chk("start_pre0", command_reg_write, 2'b00);
    @(negedge CLK); chk("start_pre1", command_reg_write, 2'b00);
    @(negedge CLK); chk("start_wr", command_reg_write, 2'b01);
    chk("start_addr", starting_address[63:0], 64'h1000);
    chk("start_lat", cyc - p0, 2);
    @(negedge CLK); chk("start_post", command_reg_write, 2'b00);
    align();

    // SET_DIR ch1 delay 30 then STOP ch1 delay 60
    push_cmd(2'd2, 1, 30, 0, 0, 64'h0);
    pa = last_push;
    push_cmd(2'd3, 1, 60, 0, 0, 64'h0);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (direction[1] == 1'b0) begin seen = 1; t_ev = cyc; end
    end
    chk("dir_fall_seen", seen, 1'b1);
    chk("dir_fall_lat", t_ev - pa, 32);
    chk("dir_ch0_kept", direction[0], 1'b1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge CLK);
      if (STOP[1]) begin seen = 1; t_ev = cyc; end
    end
    chk("stop_seen", seen, 1'b1);
    chk("stop_lat", t_ev - pa, 95);
    chk("stop_ch0_quiet", STOP[0], 1'b0);
    align();

    // fill: hold the engine in WAIT on ch1 busy, queue 8, 9th stalls until a pop
    dma_busy[1] = 1'b1;
    push_cmd(2'd1, 1, 0, 1, 0, 64'h0);
    for (int i = 0; i < 8; i++) push_cmd(2'd2, 0, 1, 0, i[0], 64'h0);
    chk("fill_level", fifo_level, 8);
    chk("fill_ready", cmd_ready, 1'b0);
    fork
      push_cmd(2'd2, 0, 1, 0, 0, 64'h0);
      begin
        repeat (10) @(negedge CLK);
        chk("stall_level", fifo_level, 8);
        chk("stall_ready", cmd_ready, 1'b0);
        dma_busy[1] = 1'b0;
      end
    join
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge CLK);
      if (seq_idle) seen = 1;
    end
    chk("fill_drained", seen, 1'b1);
    chk("fill_last_dir", direction[0], 1'b0);
    align();

    // CONTINUE ch0 with wait_idle while busy for 20 cycles
    dma_busy[0] = 1'b1;
    push_cmd(2'd1, 0, 0, 1, 0, 64'h0);
    repeat (20) @(posedge CLK);
    #1 dma_busy[0] = 1'b0;
    b_cyc = cyc;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (command_reg_continue[0]) begin seen = 1; t_ev = cyc; end
    end
    chk("cont_seen", seen, 1'b1);
    chk("cont_lat", t_ev - b_cyc, 1);
    align();

    // bad channel entry
    push_cmd(2'd0, 5, 0, 0, 0, 64'hDEAD);
    repeat (3) @(negedge CLK);
    chk("badch_err", err_badch, 1'b1);
    chk("badch_idle", seq_idle, 1'b1);
    align();

    // flush during DELAY of a START; a push on the flush edge is dropped
    push_cmd(2'd0, 1, 10, 0, 0, 64'hABCD);
    repeat (4) align();
    flush = 1; cmd_valid = 1; cmd_op = 2'd3; cmd_ch = 3'd0; cmd_delay = '0; cmd_wait_idle = 0;
    align();
    flush = 0; cmd_valid = 0;
    n_seen = 0;
    repeat (15) begin
      @(negedge CLK);
      if (command_reg_write != 0 || STOP != 0) n_seen++;
    end
    chk("flush_no_strobe", n_seen, 0);
    chk("flush_idle", seq_idle, 1'b1);
    chk("flush_addr_ch1", starting_address[127:64], 64'h0);
    align();

    // back-to-back zero-delay entries issue every 3 cycles
    push_cmd(2'd3, 0, 0, 0, 0, 64'h0);
    p0 = last_push;
    push_cmd(2'd3, 0, 0, 0, 0, 64'h0);
    push_cmd(2'd3, 0, 0, 0, 0, 64'h0);
    s_cyc.delete();
    repeat (15) begin
      @(negedge CLK);
      if (STOP[0]) s_cyc.push_back(cyc);
    end
    chk("b2b_count", s_cyc.size(), 3);
    if (s_cyc.size() == 3) begin
      chk("b2b_first", s_cyc[0] - p0, 2);
      chk("b2b_gap1", s_cyc[1] - s_cyc[0], 3);
      chk("b2b_gap2", s_cyc[2] - s_cyc[1], 3);
    end
    align();

    // async reset in the middle of a long delay
    push_cmd(2'd0, 0, 50, 0, 0, 64'h5555);
    repeat (10) align();
    #2 RESET = 0;
    #1;
    chk("mrst_write", command_reg_write, 2'b00);
    chk("mrst_dir", direction, 2'b11);
    chk("mrst_addr", starting_address, 128'h0);
    chk("mrst_level", fifo_level, 0);
    chk("mrst_idle", seq_idle, 1'b1);
    chk("mrst_err", err_badch, 1'b0);
    align();
    RESET = 1;
    repeat (70) align();
    chk("mrst_no_start", starting_address, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
